// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end feeding the IF/ID pipeline register.
//
// Issues word-aligned fetch requests over a valid/ready channel (at most one
// outstanding), accepts in-order variable-latency responses, and presents a
// PC/instruction pair downstream. One extra returned instruction can be parked
// in a hold buffer while the output is stalled. EX redirects flush everything
// and any response still owed for a stale request is discarded (DRAIN state).
//
// Optional build macro: FETCH_JAL_PREDICT_EN
//   When defined, a captured JAL response steers the next fetch to its target.
//   When undefined, the PC only advances sequentially or on redirect.
//
// Ports:
//   clk                clock, all state on rising edge
//   reset              asynchronous, active-high reset
//   imem_req_valid_o   fetch request valid
//   imem_req_ready_i   imem accepts the request this cycle
//   imem_req_addr_o    fetch address
//   imem_resp_valid_i  response valid (one per accepted request, in order)
//   imem_resp_data_i   instruction word
//   stall_i            downstream hold; output pair not consumed this cycle
//   redirect_i         control-hazard redirect / flush
//   redirect_pc_i      redirect target
//   fetch_valid_o      fetch_pc_o/fetch_instr_o hold a valid instruction
//   fetch_pc_o         PC of the presented instruction
//   fetch_instr_o      presented instruction

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_instr_o
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_instr_q, fetch_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic        req_valid;
    logic        consume;
    logic [31:0] capture_pc;

    assign consume = fetch_valid_q & ~stall_i;

`ifdef FETCH_JAL_PREDICT_EN
    logic        resp_is_jal;
    logic [31:0] jal_imm;

    assign resp_is_jal = (imem_resp_data_i[6:0] == 7'b1101111);
    // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} in [31:12].
    assign jal_imm = {{11{imem_resp_data_i[31]}}, imem_resp_data_i[31],
                      imem_resp_data_i[19:12], imem_resp_data_i[20],
                      imem_resp_data_i[30:21], 1'b0};
    // pc_q already holds inflight_pc_q + 4 while waiting for the response.
    assign capture_pc = resp_is_jal ? (inflight_pc_q + jal_imm) : pc_q;
`else
    assign capture_pc = pc_q;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        req_valid     = 1'b0;

        // Consumed output empties unless a state below refills it.
        if (consume) begin
            fetch_valid_d = 1'b0;
            fetch_pc_d    = 32'h0;
            fetch_instr_d = 32'h0;
        end

        unique case (state_q)
            StReq: begin
                req_valid = 1'b1;
                if (imem_req_ready_i) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid_i) begin
                    pc_d = capture_pc;
                    if (!fetch_valid_q || consume) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = inflight_pc_q;
                        fetch_instr_d = imem_resp_data_i;
                        state_d       = StReq;
                    end else begin
                        hold_pc_d    = inflight_pc_q;
                        hold_instr_d = imem_resp_data_i;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (consume) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = hold_pc_q;
                    fetch_instr_d = hold_instr_q;
                    state_d       = StReq;
                end
            end
            StDrain: begin
                if (imem_resp_valid_i) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // Redirect overrides everything above, including a JAL prediction.
        if (redirect_i) begin
            pc_d          = redirect_pc_i;
            fetch_valid_d = 1'b0;
            fetch_pc_d    = 32'h0;
            fetch_instr_d = 32'h0;
            hold_pc_d     = 32'h0;
            hold_instr_d  = 32'h0;
            unique case (state_q)
                // A request accepted now is owed a response we must drop.
                StReq:   state_d = imem_req_ready_i ? StDrain : StReq;
                StWait:  state_d = imem_resp_valid_i ? StReq : StDrain;
                StHold:  state_d = StReq;
                StDrain: state_d = imem_resp_valid_i ? StReq : StDrain;
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0;
            fetch_instr_q <= 32'h0;
            hold_pc_q     <= 32'h0;
            hold_instr_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
        end
    end

    assign imem_req_valid_o = req_valid & ~reset;
    assign imem_req_addr_o  = pc_q;
    assign fetch_valid_o    = fetch_valid_q;
    assign fetch_pc_o       = fetch_pc_q;
    assign fetch_instr_o    = fetch_instr_q;

endmodule
